// File: rtl/test_signal_nco.sv
// Wishbone-programmable phase-accumulator tone source with RUN and counted-burst modes.
// Single-cycle ack/err termination; signal_o is the accumulator MSB straight from the register.
module test_signal_nco #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0300,
  parameter int          ACC_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [3:0]  sel_i,
  input  logic        lock_i,
  input  logic        tagn_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        signal_o,
  output logic        running_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_BURST = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_sum;
  logic [31:0]            edge_cnt_q, edge_cnt_d, edge_cnt_inc;
  logic                   done_q, done_d;
  logic                   en_q, en_d, burst_q, burst_d;
  logic [31:0]            phase_inc_q, phase_inc_d;
  logic [31:0]            burst_len_q, burst_len_d;
  logic                   ack_q, err_q;
  logic [31:0]            dat_q, rd_val;

  logic       hit, reg_hit, bad_hit, wr, clear_w;
  logic [2:0] offs;
  logic       rise, fall;

  logic unused_ok;
  assign unused_ok = ^{lock_i, tagn_i, addr_i[1:0], phase_inc_q};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Bus decode: ack_o/err_o gate a new hit so every access terminates exactly once.
  assign offs    = addr_i[4:2];
  assign hit     = cyc_i & stb_i & (addr_i[31:5] == BASE_ADDR[31:5]) & ~ack_q & ~err_q;
  assign reg_hit = hit & (offs <= 3'd4);
  assign bad_hit = hit & (offs > 3'd4);
  assign wr      = reg_hit & we_i;
  assign clear_w = wr & (offs == 3'd0) & sel_i[0] & dat_i[2];

  assign running_o = (state_q == S_RUN) | (state_q == S_BURST) | (state_q == S_DRAIN);
  assign signal_o  = acc_q[ACC_WIDTH-1];
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rty_o     = 1'b0;
  assign dat_o     = dat_q;

  always_comb begin
    rd_val = 32'h0;
    case (offs)
      3'd0:    rd_val = {30'h0, burst_q, en_q};
      3'd1:    rd_val = phase_inc_q;
      3'd2:    rd_val = burst_len_q;
      3'd3:    rd_val = {30'h0, done_q, running_o};
      3'd4:    rd_val = edge_cnt_q;
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    en_d        = en_q;
    burst_d     = burst_q;
    phase_inc_d = phase_inc_q;
    burst_len_d = burst_len_q;
    if (wr) begin
      case (offs)
        3'd0: begin
          if (sel_i[0]) begin
            en_d    = dat_i[0];
            burst_d = dat_i[1];
          end
        end
        3'd1:    phase_inc_d = merge_lanes(phase_inc_q, dat_i, sel_i);
        3'd2:    burst_len_d = merge_lanes(burst_len_q, dat_i, sel_i);
        default: ;
      endcase
    end
  end

  assign acc_sum      = acc_q + phase_inc_q[ACC_WIDTH-1:0];
  assign rise         = ~acc_q[ACC_WIDTH-1] & acc_sum[ACC_WIDTH-1];
  assign fall         = acc_q[ACC_WIDTH-1] & ~acc_sum[ACC_WIDTH-1];
  assign edge_cnt_inc = (edge_cnt_q == 32'hFFFF_FFFF) ? edge_cnt_q : edge_cnt_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    edge_cnt_d = edge_cnt_q;
    done_d     = done_q;
    if (!en_q) begin
      state_d = S_IDLE;
      acc_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_d      = '0;
          edge_cnt_d = 32'h0;
          if (!burst_q) begin
            state_d = S_RUN;
          end else if (burst_len_q != 32'h0) begin
            state_d = S_BURST;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        // burst_mode and BURST_LEN are live here, so mid-burst rewrites apply at once.
        S_RUN, S_BURST: begin
          acc_d = acc_sum;
          if (rise) edge_cnt_d = edge_cnt_inc;
          state_d = burst_q ? S_BURST : S_RUN;
          if (burst_q && rise && (edge_cnt_inc >= burst_len_q)) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          acc_d = acc_sum;
          if (rise) edge_cnt_d = edge_cnt_inc;
          if (fall) begin
            state_d = S_DONE;
            acc_d   = '0;
            done_d  = 1'b1;
          end
        end
        S_DONE: acc_d = '0;
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
        end
      endcase
    end
    if (clear_w) begin
      edge_cnt_d = 32'h0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      edge_cnt_q  <= 32'h0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      burst_q     <= 1'b0;
      phase_inc_q <= 32'h0;
      burst_len_q <= 32'h0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      edge_cnt_q  <= edge_cnt_d;
      done_q      <= done_d;
      en_q        <= en_d;
      burst_q     <= burst_d;
      phase_inc_q <= phase_inc_d;
      burst_len_q <= burst_len_d;
      ack_q       <= reg_hit;
      err_q       <= bad_hit;
      dat_q       <= reg_hit ? rd_val : 32'h0;
    end
  end

endmodule
